// File: rtl/neuron_mac_q4_27.sv
// neuron_mac_q4_27
// Pre-activation stage that feeds the 4-slice sigmoid. It takes N_INPUTS
// (x, w) pairs in signed Q4.27 one at a time and multiply-accumulates them
// at full precision. It then adds the bias, floors the sum back to Q4.27 and
// saturates it, and holds the result on data_out until downstream takes it.
//
// State table:
//   state | meaning
//   ACC   | accepting pairs; in_ready=1, acc += x*w per accepted beat
//   FIN   | one cycle: add bias, floor, saturate, register data_out
//   OUT   | out_valid=1 until out_ready; then clear acc/count, back to ACC
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   input pair handshake
//   x_in, w_in            signed Q4.27 activation and weight
//   bias                  signed Q4.27 bias, sampled in FIN only
//   out_valid / out_ready result handshake
//   data_out              registered, saturated Q4.27 result
//   count                 pairs accepted into the current result (debug)
module neuron_mac_q4_27 #(
  parameter int DATA_W   = 32,
  parameter int FRAC_W   = 27,
  parameter int N_INPUTS = 4,
  parameter int ACC_W    = 72
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_W-1:0]                 x_in,
  input  logic [DATA_W-1:0]                 w_in,
  input  logic [DATA_W-1:0]                 bias,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_W-1:0]                 data_out,
  output logic [$clog2(N_INPUTS+1)-1:0]     count
);

  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_INPUTS - 1);

  // Q4.27 limits expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] C_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] C_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_ACC = 2'd0,
    S_FIN = 2'd1,
    S_OUT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [ACC_W-1:0]    r_acc;
  logic [CNT_W-1:0]           r_count;
  logic [DATA_W-1:0]          r_data_out;

  logic                       w_accept;
  logic [2*DATA_W-1:0]        w_x_ext;
  logic [2*DATA_W-1:0]        w_w_ext;
  logic [2*DATA_W-1:0]        w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_bias_sh;
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [ACC_W-1:0]    w_q;
  logic [DATA_W-1:0]          w_sat;

  // Sign-extending both operands to 2*DATA_W before multiplying makes the
  // low 2*DATA_W bits of the product the exact signed Q8.54 result.
  assign w_x_ext    = {{DATA_W{x_in[DATA_W-1]}}, x_in};
  assign w_w_ext    = {{DATA_W{w_in[DATA_W-1]}}, w_in};
  assign w_prod     = w_x_ext * w_w_ext;
  assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};

  // Bias is aligned to the Q8.54 accumulator scale. The arithmetic right
  // shift then floors the sum back to Q4.27 (round toward -inf).
  assign w_bias_sh  = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} << FRAC_W;
  assign w_sum      = r_acc + w_bias_sh;
  assign w_q        = w_sum >>> FRAC_W;

  always_comb begin
    w_sat = w_q[DATA_W-1:0];
    if (w_q > C_MAX) begin
      w_sat = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (w_q < C_MIN) begin
      w_sat = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end

  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid && (r_count == C_LAST)) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_state_nxt = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_ACC;
        end
      end
      default: begin
        w_state_nxt = S_ACC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_count    <= '0;
      r_data_out <= '0;
    end else begin
      case (r_state)
        S_ACC: begin
          if (w_accept) begin
            r_acc   <= r_acc + w_prod_ext;
            r_count <= r_count + CNT_W'(1);
          end
        end
        S_FIN: begin
          r_data_out <= w_sat;
        end
        S_OUT: begin
          if (out_ready) begin
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign data_out = r_data_out;
  assign count    = r_count;

endmodule

// File: tb/tb_neuron_mac_q4_27.sv
module tb_neuron_mac_q4_27;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_in;
  logic [31:0] w_in;
  logic [31:0] bias;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  neuron_mac_q4_27 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .w_in      (w_in),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic [3:0][31:0] x;
    logic [3:0][31:0] w;
    logic [31:0]      b;
    logic [7:0]       gap;
    logic [31:0]      exp_out;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Beat 0 uses (x0, w0); beats 1..3 use (xr, wr).
  function automatic vec_t mk(input logic [31:0] x0, input logic [31:0] w0,
                              input logic [31:0] xr, input logic [31:0] wr,
                              input logic [31:0] b, input int g, input logic [31:0] e);
    vec_t v;
    v.x       = {xr, xr, xr, x0};
    v.w       = {wr, wr, wr, w0};
    v.b       = b;
    v.gap     = 8'(g);
    v.exp_out = e;
    return v;
  endfunction

  // Exact rational arithmetic: sum of real products plus bias, then the
  // floor of (sum / 2^27), clamped to the signed 32-bit range.
  function automatic logic [31:0] model(input logic [3:0][31:0] xs,
                                        input logic [3:0][31:0] ws,
                                        input logic [31:0] b);
    logic signed [127:0] s;
    logic signed [127:0] q;
    logic signed [127:0] scale;
    longint p;
    scale = 128'sd134217728;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      p = longint'($signed(xs[i])) * longint'($signed(ws[i]));
      s = s + p;
    end
    p = longint'($signed(b));
    s = s + p * scale;
    q = s / scale;
    if ((s < 0) && ((s % scale) != 0)) q = q - 1;
    if (q > 128'sd2147483647) return 32'h7FFF_FFFF;
    if (q < -128'sd2147483648) return 32'h8000_0000;
    return q[31:0];
  endfunction

  task automatic run_vec(input logic [3:0][31:0] xs, input logic [3:0][31:0] ws,
                         input logic [31:0] b, input int gap_max,
                         output logic [31:0] res);
    int lat;
    bias = b;
    for (int i = 0; i < 4; i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(gap_max, 0)) begin
          in_valid = 1'b0;
          x_in = $urandom;
          w_in = $urandom;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      x_in = xs[i];
      w_in = ws[i];
      check("in_ready_acc", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    x_in = $urandom;
    w_in = $urandom;
    check("count_fin", {29'd0, count}, 32'd4);
    check("fin_no_valid", {31'd0, out_valid}, 32'd0);
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd2);
    res = data_out;
    if (out_ready) begin
      @(posedge clk); #1;
      check("valid_drop", {31'd0, out_valid}, 32'd0);
      check("count_clear", {29'd0, count}, 32'd0);
    end
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(2, 0) == 0) return r;
    return {{6{r[25]}}, r[25:0]};
  endfunction

  logic [31:0]      res;
  logic [3:0][31:0] rx;
  logic [3:0][31:0] rw;
  logic [31:0]      rb;
  logic [31:0]      held;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; x_in = '0; w_in = '0; bias = '0; out_ready = 1'b1;

    tbl[0] = mk(32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'h0, 0, 32'h2000_0000);
    tbl[1] = mk(32'hF800_0000, 32'h0400_0000, 32'hF800_0000, 32'h0400_0000, 32'h0800_0000, 0, 32'hF800_0000);
    tbl[2] = mk(32'h0000_0001, 32'h0000_0001, 32'h0, 32'h0, 32'h0, 0, 32'h0000_0000);
    tbl[3] = mk(32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h0, 32'h0, 0, 32'hFFFF_FFFF);
    tbl[4] = mk(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 0, 32'h7FFF_FFFF);
    tbl[5] = mk(32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 0, 32'h8000_0000);
    tbl[6] = mk(32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'h0800_0000, 32'h0, 3, 32'h2000_0000);

    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int t = 0; t < 7; t++) begin
      run_vec(tbl[t].x, tbl[t].w, tbl[t].b, int'(tbl[t].gap), res);
      check($sformatf("table_%0d", t), res, tbl[t].exp_out);
    end

    // Backpressure: result held, inputs blocked, stray in_valid ignored.
    out_ready = 1'b0;
    run_vec(tbl[0].x, tbl[0].w, 32'h0, 0, res);
    check("bp_result", res, 32'h2000_0000);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      x_in = 32'h0800_0000;
      w_in = $urandom;
      @(posedge clk); #1;
      check("bp_data_stable", data_out, 32'h2000_0000);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {31'd0, out_valid}, 32'd0);
    check("bp_data_retained", data_out, 32'h2000_0000);
    run_vec(tbl[0].x, tbl[0].w, 32'h0, 0, res);
    check("after_bp_fresh_acc", res, 32'h2000_0000);

    // Reset in the middle of accumulation.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      x_in = 32'h0800_0000;
      w_in = 32'h0800_0000;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("mid_count", {29'd0, count}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", {29'd0, count}, 32'd0);
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(tbl[0].x, tbl[0].w, 32'h0, 0, res);
    check("after_rst_basic", res, 32'h2000_0000);

    // Randomized vectors against the reference model.
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 4; i++) begin
        rx[i] = rnd_op();
        rw[i] = rnd_op();
      end
      rb = rnd_op();
      out_ready = ($urandom_range(3, 0) == 0) ? 1'b0 : 1'b1;
      run_vec(rx, rw, rb, 2, res);
      check($sformatf("rand_%0d", n), res, model(rx, rw, rb));
      if (!out_ready) begin
        held = res;
        repeat ($urandom_range(4, 1)) begin
          in_valid = $urandom_range(1, 0) == 1;
          @(posedge clk); #1;
          check("rand_hold", data_out, held);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("rand_release", {31'd0, out_valid}, 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_mac_q4_27.md
Name: neuron_mac_q4_27

Overview:
- Sequential pre-activation stage directly upstream of the 4-slice sigmoid.
- Accepts a stream of N_INPUTS (x, w) pairs in signed Q4.27: 1 sign bit, 4 integer bits, 27 fraction bits.
- Multiply-accumulates the pairs, adds a bias, rounds toward −inf, saturates to Q4.27, and presents the result on data_out.
- data_out connects straight to the sigmoid's 32-bit data_in.

Parameters:
- DATA_W, 32, operand/result width (Q4.27).
- FRAC_W, 27, fraction bits.
- N_INPUTS, 4, pairs accumulated per result (≥1).
- ACC_W, 72, accumulator width; must be ≥ 2*DATA_W + clog2(N_INPUTS) + 1.

Ports:
- clk, input, 1, single clock; rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, x_in/w_in valid.
- in_ready, output, 1, block can accept a pair.
- x_in, input, DATA_W, signed activation, Q4.27.
- w_in, input, DATA_W, signed weight, Q4.27.
- bias, input, DATA_W, signed bias, Q4.27; sampled in FIN state only.
- out_valid, output, 1, data_out valid.
- out_ready, input, 1, downstream accepts data_out.
- data_out, output, DATA_W, signed saturated result, Q4.27.
- count, output, clog2(N_INPUTS+1), pairs accepted in the current result (debug).

Behaviour:
- Reset (async, rst_n=0):
  - state=ACC, acc=0, count=0.
  - out_valid=0, data_out=0, in_ready=1 immediately after release.
- States:
  - ACC: in_ready=1, out_valid=0.
    - On in_valid&in_ready: acc += sign-extended (x_in*w_in), a full 64-bit Q8.54 product; count++.
    - When the accepted beat is beat number N_INPUTS: next state FIN.
  - FIN (one cycle): in_ready=0.
    - sum = acc + (sign-extended bias << FRAC_W).
    - q = sum >>> FRAC_W (arithmetic shift, i.e. floor).
    - If q > 2^31−1, data_out=0x7FFF_FFFF. If q < −2^31, data_out=0x8000_0000. Otherwise data_out=q[31:0].
    - Next state OUT.
  - OUT: out_valid=1, in_ready=0.
    - data_out held stable while out_valid & !out_ready.
    - On out_ready: out_valid=0, acc=0, count=0, next state ACC.
- Latency: the Nth pair is accepted on cycle T; out_valid rises at T+2 (FIN at T+1).
- Throughput: N_INPUTS+2 cycles per result when out_ready is held at 1.
- No overlap: in_ready is low through FIN and OUT. in_valid is ignored then; x_in/w_in are never sampled.
- in_valid may deassert between beats; count holds and acc holds.
- No intermediate saturation. acc is wide enough that overflow cannot occur for any operand values.
- data_out is registered and retains its last value after the handshake, until the next FIN.
- Reset asserted in any state aborts the operation: no output for the partial sum, all registers return to reset values.
- Simultaneous events: in_valid is don't-care in OUT. Reset has priority over everything.

Test Plan:
- Basic: 4× (x=0x0800_0000 (1.0), w=0x0800_0000), bias=0 -> data_out=0x2000_0000 (4.0); out_valid exactly 2 cycles after the 4th accept.
- Signed/bias: 4× (x=0xF800_0000 (−1.0), w=0x0400_0000 (0.5)), bias=0x0800_0000 (1.0) -> data_out=0xF800_0000 (−1.0).
- Floor rounding:
  - Beat 1 x=0x0000_0001, w=0x0000_0001, then 3× zeros, bias=0 -> 0x0000_0000.
  - Repeat with x=0xFFFF_FFFF -> 0xFFFF_FFFF (−2^−27).
- Saturation:
  - 4× (x=0x7FFF_FFFF, w=0x7FFF_FFFF) -> 0x7FFF_FFFF.
  - 4× (x=0x8000_0000, w=0x7FFF_FFFF) -> 0x8000_0000.
- Handshake/backpressure:
  - Insert in_valid gaps between beats -> same result as gap-free.
  - Hold out_ready=0 for 5 cycles -> data_out stable, in_ready=0, in_valid pulses ignored.
  - Next result starts from acc=0.
- Reset mid-op: pull rst_n low after 2 beats -> out_valid=0, count=0 asynchronously. A subsequent full basic vector gives 0x2000_0000.
